// File: rtl/vx_decode_sched.sv
// Decode-to-ibuf scheduler: per-slot credit flow control, per-warp branch stall, one-entry output register.
// Optional stall counters are built when VX_DECODE_SCHED_PERF_EN is defined; otherwise the perf ports read 0.
module vx_decode_sched #(
    parameter int NUM_WARPS   = 8,
    parameter int ISSUE_WIDTH = 4,
    parameter int IBUF_SIZE   = 4,
    parameter int DATAW       = 128,
    localparam int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [NW_WIDTH-1:0]    in_wid,
    input  logic                   in_is_branch,
    input  logic [DATAW-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [NW_WIDTH-1:0]    out_wid,
    output logic [DATAW-1:0]       out_data,
    input  logic                   out_ready,
    input  logic [ISSUE_WIDTH-1:0] ibuf_pop,
    input  logic                   br_resolve_valid,
    input  logic [NW_WIDTH-1:0]    br_resolve_wid,
    output logic [31:0]            perf_stall_credit,
    output logic [31:0]            perf_stall_branch
);

    localparam int SW = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
    localparam int CW = $clog2(IBUF_SIZE + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(IBUF_SIZE);

    logic [CW-1:0]        credit [ISSUE_WIDTH];
    logic [NUM_WARPS-1:0] br_pending;
    logic [SW-1:0]        in_slot;
    logic                 credit_zero;
    logic                 pend_hit;
    logic                 out_free;
    logic                 accept;

    // ISSUE_WIDTH is a power of two, so wid mod ISSUE_WIDTH is just the low wid bits.
    generate
        if (ISSUE_WIDTH == 1) begin : g_one_slot
            assign in_slot = '0;
        end else begin : g_slots
            assign in_slot = in_wid[SW-1:0];
        end
    endgenerate

    assign credit_zero = (credit[in_slot] == '0);
    assign pend_hit    = br_pending[in_wid];
    assign out_free    = !out_valid || out_ready;
    assign in_ready    = reset_n && !pend_hit && !credit_zero && out_free;
    assign accept      = in_valid && in_ready;

    // A credit is taken at accept time, so the output register counts as ibuf occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                credit[s] <= CREDIT_MAX;
            end
        end else begin
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                if (ibuf_pop[s] && !(accept && in_slot == SW'(s))) begin
                    if (credit[s] != CREDIT_MAX) begin
                        credit[s] <= credit[s] + CW'(1);
                    end
                end else if (!ibuf_pop[s] && accept && in_slot == SW'(s)) begin
                    credit[s] <= credit[s] - CW'(1);
                end
            end
        end
    end

    generate
        for (genvar gs = 0; gs < ISSUE_WIDTH; gs++) begin : g_pop_chk
            assert property (@(posedge clk) disable iff (!reset_n)
                !(ibuf_pop[gs] && credit[gs] == CREDIT_MAX));
        end
    endgenerate

    // Setting a pending branch has priority over a same-cycle resolve for the same warp.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_pending <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (accept && in_is_branch && in_wid == NW_WIDTH'(w)) begin
                    br_pending[w] <= 1'b1;
                end else if (br_resolve_valid && br_resolve_wid == NW_WIDTH'(w)) begin
                    br_pending[w] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_wid   <= '0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_wid   <= in_wid;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef VX_DECODE_SCHED_PERF_EN
    logic [31:0] stall_credit_q;
    logic [31:0] stall_branch_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_credit_q <= '0;
            stall_branch_q <= '0;
        end else begin
            if (in_valid && credit_zero) begin
                stall_credit_q <= stall_credit_q + 32'd1;
            end
            if (in_valid && pend_hit && !credit_zero) begin
                stall_branch_q <= stall_branch_q + 32'd1;
            end
        end
    end

    assign perf_stall_credit = stall_credit_q;
    assign perf_stall_branch = stall_branch_q;
`else
    assign perf_stall_credit = 32'd0;
    assign perf_stall_branch = 32'd0;
`endif

endmodule

// File: tb/tb_vx_decode_sched.sv
// Directed-vector bench for vx_decode_sched: stimulus pushes expected outputs into a scoreboard queue,
// an independent monitor pops and compares every transfer toward the ibuf.
module tb_vx_decode_sched;

    localparam int NW    = 3;
    localparam int DATAW = 128;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic [NW-1:0]    in_wid;
    logic             in_is_branch;
    logic [DATAW-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [NW-1:0]    out_wid;
    logic [DATAW-1:0] out_data;
    logic             out_ready;
    logic [3:0]       ibuf_pop;
    logic             br_resolve_valid;
    logic [NW-1:0]    br_resolve_wid;
    logic [31:0]      perf_stall_credit;
    logic [31:0]      perf_stall_branch;

    int checks   = 0;
    int failures = 0;
    int unsigned seq = 0;
    logic [DATAW-1:0]    lastAcceptData;
    logic [NW+DATAW-1:0] sbQueue [$];

    vx_decode_sched dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_wid           (in_wid),
        .in_is_branch     (in_is_branch),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_wid          (out_wid),
        .out_data         (out_data),
        .out_ready        (out_ready),
        .ibuf_pop         (ibuf_pop),
        .br_resolve_valid (br_resolve_valid),
        .br_resolve_wid   (br_resolve_wid),
        .perf_stall_credit(perf_stall_credit),
        .perf_stall_branch(perf_stall_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DATAW-1:0] actual,
                               input logic [DATAW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Called at posedge+1; drives one cycle, checks in_ready at the negedge and records accepts.
    task automatic applyStimulus(input logic v, input logic [NW-1:0] wid, input logic br,
                                 input logic ordy, input logic [3:0] pop, input logic rv,
                                 input logic [NW-1:0] rwid, input logic expReady,
                                 input string name);
        logic [DATAW-1:0] data;
        seq++;
        data = {4{seq}};
        in_valid         = v;
        in_wid           = wid;
        in_is_branch     = br;
        in_data          = data;
        out_ready        = ordy;
        ibuf_pop         = pop;
        br_resolve_valid = rv;
        br_resolve_wid   = rwid;
        @(negedge clk);
        checkOutput(name, {127'd0, in_ready}, {127'd0, expReady});
        if (v && in_ready) begin
            sbQueue.push_back({wid, data});
            lastAcceptData = data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkPerf(input string name, input logic [31:0] expCredit,
                             input logic [31:0] expBranch);
`ifdef VX_DECODE_SCHED_PERF_EN
        checkOutput({name, "_credit"}, {96'd0, perf_stall_credit}, {96'd0, expCredit});
        checkOutput({name, "_branch"}, {96'd0, perf_stall_branch}, {96'd0, expBranch});
`else
        checkOutput({name, "_credit"}, {96'd0, perf_stall_credit}, {96'd0, 32'd0 & expCredit});
        checkOutput({name, "_branch"}, {96'd0, perf_stall_branch}, {96'd0, 32'd0 & expBranch});
`endif
    endtask

    // Monitor: a transfer happens at the next posedge whenever out_valid && out_ready at the negedge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (sbQueue.size() == 0) begin
                failures++;
                $display("[TB] FAIL sb_unexpected: got wid=%0d data=%0h expected no output",
                         out_wid, out_data);
            end else begin
                logic [NW+DATAW-1:0] exp;
                exp = sbQueue.pop_front();
                if ({out_wid, out_data} !== exp) begin
                    failures++;
                    $display("[TB] FAIL sb_data: got wid=%0d data=%0h expected wid=%0d data=%0h",
                             out_wid, out_data, exp[NW+DATAW-1:DATAW], exp[DATAW-1:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b1; in_wid = 3'd1; in_is_branch = 1'b0; in_data = '0;
        out_ready = 1'b1; ibuf_pop = 4'd0; br_resolve_valid = 1'b0; br_resolve_wid = '0;
        lastAcceptData = '0;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("rst_in_ready",  {127'd0, in_ready},  '0);
        checkOutput("rst_out_valid", {127'd0, out_valid}, '0);
        checkOutput("rst_out_wid",   {125'd0, out_wid},   '0);
        checkOutput("rst_out_data",  out_data,            '0);
        checkPerf("rst_perf", 32'd0, 32'd0);
        reset_n = 1'b1;

        // Slot 1 drains its four credits, then stalls.
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 3'd1, 0, 1, 4'b0000, 0, 3'd0, 1, "credit_accept");
        applyStimulus(1, 3'd1, 0, 1, 4'b0000, 0, 3'd0, 0, "credit_empty");
        checkPerf("perf_after_empty", 32'd1, 32'd0);

        // Pop returns one credit; pop plus accept on the same slot leaves it at 1.
        applyStimulus(1, 3'd1, 0, 1, 4'b0010, 0, 3'd0, 0, "pop_while_empty");
        applyStimulus(1, 3'd1, 0, 1, 4'b0010, 0, 3'd0, 1, "pop_and_accept");
        applyStimulus(1, 3'd1, 0, 1, 4'b0000, 0, 3'd0, 1, "last_credit");
        applyStimulus(0, 3'd1, 0, 1, 4'b0000, 0, 3'd0, 0, "slot1_empty_again");

        // Branch on warp 2 blocks it until resolved.
        applyStimulus(1, 3'd2, 1, 1, 4'b0000, 0, 3'd0, 1, "branch_accept");
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 3'd2, 0, 1, 4'b0000, 0, 3'd0, 0, "branch_stall");
        applyStimulus(1, 3'd2, 0, 1, 4'b0000, 1, 3'd2, 0, "branch_resolve_cycle");
        applyStimulus(1, 3'd2, 0, 1, 4'b0000, 0, 3'd0, 1, "branch_released");
        checkPerf("perf_after_branch", 32'd2, 32'd5);

        // Output backpressure holds the register and blocks acceptance.
        applyStimulus(1, 3'd0, 0, 1, 4'b0000, 0, 3'd0, 1, "bp_first");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 3'd0, 0, 0, 4'b0000, 0, 3'd0, 0, "bp_stall");
            checkOutput("bp_out_valid", {127'd0, out_valid}, {127'd0, 1'b1});
            checkOutput("bp_out_wid",   {125'd0, out_wid},   '0);
            checkOutput("bp_out_data",  out_data,            lastAcceptData);
        end
        applyStimulus(1, 3'd0, 0, 1, 4'b0000, 0, 3'd0, 1, "bp_release");
        applyStimulus(1, 3'd3, 1, 1, 4'b0000, 0, 3'd0, 1, "back_to_back_branch");
        checkOutput("b2b_out_wid", {125'd0, out_wid}, {125'd0, 3'd3});
        applyStimulus(0, 3'd3, 0, 0, 4'b0000, 0, 3'd0, 0, "pending3_blocked");

        // Mid-stream asynchronous reset drops the held entry and restores all state.
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {127'd0, out_valid}, '0);
        checkOutput("midrst_in_ready",  {127'd0, in_ready},  '0);
        sbQueue.delete();
        @(posedge clk); @(posedge clk); #1;
        checkPerf("perf_after_midrst", 32'd0, 32'd0);
        reset_n = 1'b1;
        applyStimulus(1, 3'd3, 0, 1, 4'b0000, 0, 3'd0, 1, "wid3_after_reset");
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 3'd0, 0, 1, 4'b0000, 0, 3'd0, 1, "slot0_full_credit");
        applyStimulus(1, 3'd0, 0, 1, 4'b0000, 0, 3'd0, 0, "slot0_empty");
        applyStimulus(0, 3'd5, 0, 1, 4'b0000, 0, 3'd0, 1, "idle");

        // Same-cycle set and resolve on warp 5: set wins.
        applyStimulus(1, 3'd5, 1, 1, 4'b0000, 1, 3'd5, 1, "set_clear_same");
        applyStimulus(1, 3'd5, 0, 1, 4'b0000, 0, 3'd0, 0, "set_wins");
        applyStimulus(1, 3'd5, 0, 1, 4'b0000, 1, 3'd5, 0, "resolve_5");
        applyStimulus(1, 3'd5, 0, 1, 4'b0000, 0, 3'd0, 1, "wid5_released");
        applyStimulus(1, 3'd6, 0, 1, 4'b0000, 1, 3'd6, 1, "clear_not_pending");
        applyStimulus(1, 3'd6, 0, 1, 4'b0000, 0, 3'd0, 1, "clear_noop");

        applyStimulus(0, 3'd6, 0, 1, 4'b0000, 0, 3'd0, 1, "drain0");
        applyStimulus(0, 3'd6, 0, 1, 4'b0000, 0, 3'd0, 1, "drain1");
        checkOutput("sb_empty", 128'(sbQueue.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
